t07_fpu_sequencer: RTL
======================

# t07_fpu_sequencer

Issue controller between the CPU execute stage and `t07_FPU`. It accepts one floating-point operation at a time over a valid/ready request channel and resolves the rounding mode. It drives the FPU's operands, op and fcsr inputs, waits on the FPU `busy`, and returns the result over a valid/ready response channel. It owns the architectural fcsr (frm + sticky fflags), with a CSR read/write port.

## Interface
Parameters:
- `TIMEOUT`, 64: max WAIT cycles before the operation is aborted with an error.
- `OP_W`, 5: FPU op code width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in OP_W: FPU operation code.
- `req_rm` in 3: instruction rounding mode; 3'b111 means dynamic.
- `req_a`, `req_b`, `req_c` in 32 each: operands.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 32: FPU result.
- `rsp_flags` out 7: FPU flags captured for this operation.
- `rsp_err` out 1: illegal rounding mode or timeout.
- `fpu_op` out OP_W: drives the FPU `FPUOp` input.
- `fpu_a`, `fpu_b`, `fpu_c` out 32 each: drive the FPU `valA`, `valB` and `valC` inputs.
- `fpu_fcsr` out 32: drives the FPU `fcsr_in` input, as {24'b0, rm_eff, fflags}.
- `fpu_result` in 32: FPU result.
- `fpu_flags` in 7: FPU flags. Bits [4:0] are NV, DZ, OF, UF, NX; bits [6:5] are pass-through.
- `fpu_busy` in 1: FPU busy.
- `csr_we` in 1: fcsr write strobe.
- `csr_wdata` in 8: {frm, fflags}.
- `csr_rdata` out 8: current {frm, fflags}.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch op, operands and rm_eff, then go to ISSUE.
  - rm_eff is `req_rm`, or frm when `req_rm`=3'b111.
  - If rm_eff is 3'b101 or 3'b110, the request is illegal. Go straight to DONE with `rsp_err`=1, result 0 and flags 0. The FPU is not issued.
- **ISSUE**
  - One cycle. `fpu_*` are driven from the latched values.
  - Go to WAIT unconditionally.
- **WAIT**
  - Each cycle, if `fpu_busy`=0: capture `fpu_result` and `fpu_flags`, OR `fpu_flags[4:0]` into sticky fflags, and go to DONE.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT-1 and `fpu_busy` is still 1: go to DONE with `rsp_err`=1, result 0, and no flag accumulation.
- **DONE**
  - `rsp_valid`=1; the response is held stable until `rsp_ready`.
  - On `rsp_valid`&&`rsp_ready`: go to IDLE. A new request can be accepted the cycle after the handshake, never the same cycle.
- `fpu_*` outputs keep the latched values from ISSUE through DONE. In IDLE they are all 0.
- CSR port
  - `csr_rdata` = {frm, fflags}, combinational from the register.
  - A `csr_we` write takes effect at the next edge in any state.
  - If a `csr_we` write coincides with a WAIT-capture accumulation, the CSR write wins and that operation's flags are discarded.
  - An in-flight operation keeps the rm_eff latched at acceptance, even if frm is written mid-operation.

## Timing
- Reset values: `req_ready`=0 during reset and 1 after release; all other outputs 0; fcsr = 8'h00; state IDLE; wait counter 0.
- Latency, for a request accepted at edge E0:
  - ISSUE runs in cycle E0–E1.
  - The first WAIT sample is at E2.
  - If the FPU is not busy, `rsp_valid` rises after E2. Minimum accept-to-response is 2 cycles.
- Each additional busy cycle adds one cycle of latency. Timeout response comes after at most TIMEOUT+1 cycles.
- Illegal rm: `rsp_valid` one cycle after acceptance.
- Throughput: at most one operation every 3 cycles, 4 including the response handshake.
- Reset asserted mid-operation aborts immediately. There is no response, fflags are cleared, and `fpu_*` go to 0.

## Structure
- Package `t07_fpu_pkg`:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - rm encodings RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7;
  - fcsr field positions: fflags [4:0], frm [7:5];
  - flag bit indices.
- Sub-module `t07_fpu_fcsr` holds the frm/fflags register, CSR write priority and sticky OR. The FSM and latches stay in the top.

## Test plan
- **Static rm, non-busy FPU.** frm=0, `req_rm`=3'b001, FPU busy=0, result 32'h40A00000, flags 7'b0000001. Expect:
  - `fpu_fcsr`[7:5]=001 in ISSUE;
  - `rsp_valid` 2 cycles after acceptance with result 32'h40A00000;
  - `csr_rdata`=8'h01.
- **Dynamic rm, busy FPU.** frm=3'b010, `req_rm`=3'b111, FPU busy for 5 cycles. Expect `fpu_fcsr`[7:5]=010, response at cycle 7, and fflags ORed with the prior value.
- **Illegal rm.** `req_rm`=3'b101. Expect `rsp_err`=1 one cycle after acceptance, `fpu_op` stays 0, fcsr unchanged.
- **Timeout.** TIMEOUT=8, busy held high. Expect `rsp_err`=1, result 0, fflags unchanged.
- **Backpressure.** `rsp_ready`=0 for 4 cycles. Expect the response held stable, `req_ready`=0 throughout, and a new request accepted one cycle after the handshake.
- **Collision and reset.** `csr_we` with 8'hE0 on the capture cycle gives fcsr=8'hE0 (op flags dropped). `rst` pulsed during WAIT gives all outputs 0, no response, and `csr_rdata`=0.

Source files
------------

// File: rtl/t07_fpu_pkg.sv
// Shared types and encodings for the FPU issue sequencer: FSM states,
// rounding-mode encodings, fcsr field layout and flag positions.
package t07_fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Rounding-mode encodings; DYN selects frm from the fcsr.
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;

  // fcsr layout: fflags in [4:0], frm in [7:5].
  localparam int FFLAGS_LSB = 0;
  localparam int FFLAGS_W   = 5;
  localparam int FRM_LSB    = 5;
  localparam int FRM_W      = 3;
  localparam int FCSR_W     = 8;

  // Bit positions of the accrued exception flags.
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // The two reserved encodings (3'b101, 3'b110) are the only illegal ones.
  function automatic logic rm_is_legal(input logic [2:0] rm);
    logic ok;
    case (rm)
      RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM, RM_DYN: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Effective rounding mode: the instruction field, or frm when dynamic.
  function automatic logic [2:0] rm_resolve(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

  // Map the FPU's exception flags onto the accrued fflags field.
  function automatic logic [FFLAGS_W-1:0] sticky_flags(input logic [FFLAGS_W-1:0] f);
    logic [FFLAGS_W-1:0] r;
    r          = '0;
    r[FLAG_NV] = f[FLAG_NV];
    r[FLAG_DZ] = f[FLAG_DZ];
    r[FLAG_OF] = f[FLAG_OF];
    r[FLAG_UF] = f[FLAG_UF];
    r[FLAG_NX] = f[FLAG_NX];
    return r;
  endfunction

endpackage

// File: rtl/t07_fpu_fcsr.sv
// Architectural fcsr (frm + sticky fflags). A CSR write always wins over a
// same-cycle flag accumulation from a completing operation.
module t07_fpu_fcsr
  import t07_fpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_we,
  input  logic [FCSR_W-1:0]   csr_wdata,
  input  logic                acc_en,
  input  logic [FFLAGS_W-1:0] acc_flags,
  output logic [FRM_W-1:0]    frm,
  output logic [FFLAGS_W-1:0] fflags
);

  logic [FRM_W-1:0]    frm_q, frm_d;
  logic [FFLAGS_W-1:0] fflags_q, fflags_d;

  // Next fcsr value: CSR write first, otherwise OR in the operation's flags.
  always_comb begin
    frm_d    = frm_q;
    fflags_d = fflags_q;
    if (csr_we) begin
      frm_d    = csr_wdata[FRM_LSB +: FRM_W];
      fflags_d = csr_wdata[FFLAGS_LSB +: FFLAGS_W];
    end else if (acc_en) begin
      fflags_d = fflags_q | sticky_flags(acc_flags);
    end
  end

  // fcsr register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q    <= '0;
      fflags_q <= '0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
    end
  end

  assign frm    = frm_q;
  assign fflags = fflags_q;

endmodule

// File: rtl/t07_fpu_sequencer.sv
// Issue controller between the execute stage and the FPU: accepts one op,
// resolves the rounding mode, drives the FPU, waits on busy (with timeout)
// and returns the result over a valid/ready response channel.
module t07_fpu_sequencer
  import t07_fpu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int OP_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [2:0]      req_rm,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [31:0]     req_c,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic [6:0]      rsp_flags,
  output logic            rsp_err,
  output logic [OP_W-1:0] fpu_op,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  output logic [31:0]     fpu_c,
  output logic [31:0]     fpu_fcsr,
  input  logic [31:0]     fpu_result,
  input  logic [6:0]      fpu_flags,
  input  logic            fpu_busy,
  input  logic            csr_we,
  input  logic [7:0]      csr_wdata,
  output logic [7:0]      csr_rdata
);

  // The counter only has to reach TIMEOUT-1.
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                issued_q, issued_d;
  logic                err_q, err_d;

  logic [OP_W-1:0]     op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         c_q, c_d;
  logic [FRM_W-1:0]    rm_q, rm_d;
  logic [31:0]         result_q, result_d;
  logic [6:0]          flags_q, flags_d;

  logic [FRM_W-1:0]    frm;
  logic [FFLAGS_W-1:0] fflags;
  logic [FRM_W-1:0]    rm_eff;
  logic                acc_en;

  assign rm_eff = rm_resolve(req_rm, frm);

  // FSM next state, operand/result latches and wait counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    err_d    = err_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    rm_d     = rm_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rm_d = rm_eff;
          if (!rm_is_legal(rm_eff)) begin
            // Reserved rounding mode: answer with an error, never touch the FPU.
            state_d  = ST_DONE;
            err_d    = 1'b1;
            issued_d = 1'b0;
            result_d = '0;
            flags_d  = '0;
          end else begin
            state_d  = ST_ISSUE;
            err_d    = 1'b0;
            issued_d = 1'b1;
            op_d     = req_op;
            a_d      = req_a;
            b_d      = req_b;
            c_d      = req_c;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (!fpu_busy) begin
          state_d  = ST_DONE;
          result_d = fpu_result;
          flags_d  = fpu_flags;
          acc_en   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          // FPU never came back: abort without accruing any flags.
          state_d  = ST_DONE;
          err_d    = 1'b1;
          result_d = '0;
          flags_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d  = ST_IDLE;
          issued_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state; reset aborts any in-flight operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      err_q    <= err_d;
    end
  end

  // Data latches; their outputs are gated by control state, so no reset.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    a_q      <= a_d;
    b_q      <= b_d;
    c_q      <= c_d;
    rm_q     <= rm_d;
    result_q <= result_d;
    flags_q  <= flags_d;
  end

  t07_fpu_fcsr u_fcsr (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .acc_en    (acc_en),
    .acc_flags (fpu_flags[FFLAGS_W-1:0]),
    .frm       (frm),
    .fflags    (fflags)
  );

  assign req_ready  = (state_q == ST_IDLE) & ~rst;
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = rsp_valid ? result_q : 32'b0;
  assign rsp_flags  = rsp_valid ? flags_q  : 7'b0;
  assign rsp_err    = rsp_valid & err_q;

  // FPU inputs follow the latched op only while a legal op is in flight.
  assign fpu_op   = issued_q ? op_q : '0;
  assign fpu_a    = issued_q ? a_q  : 32'b0;
  assign fpu_b    = issued_q ? b_q  : 32'b0;
  assign fpu_c    = issued_q ? c_q  : 32'b0;
  assign fpu_fcsr = issued_q ? {24'b0, rm_q, fflags} : 32'b0;

  assign csr_rdata = {frm, fflags};

endmodule
